qtree_cfg_loader: RTL and testbench
===================================

Name: qtree_cfg_loader

Overview:
- Streams quadtree node records (stage, addr, l/m/r keys) into the per-stage node RAMs of the lookup pipeline, generalised over stage count, address width and key width.
- Optionally reads each record back and checks it, and holds off lookups while a load is in progress.
- Sits between the host or config-file feeder and the stage RAM write/read ports of the qtree lookup top.

Parameters:
- STAGES, 8, number of tree stages / node RAMs (≥2)
- A_WIDTH, 8, node RAM address width
- D_WIDTH, 16, width of each key field l, m, r
- VERIFY_EN, 1, 1 = read back and compare each record, 0 = write only
- RD_LATENCY, 1, RAM read latency in cycles (≥1)
- SW = $clog2(STAGES), derived, stage index width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- rec_valid_i  in  1  record valid
- rec_ready_o  out  1  record ready
- rec_stage_i  in  SW  target stage
- rec_addr_i  in  A_WIDTH  node address
- rec_data_i  in  3*D_WIDTH  packed {l,m,r}, l in MSBs
- rec_last_i  in  1  final record of this load
- clear_err_i  in  1  clear error status
- wr_en_o  out  STAGES  one-hot RAM write strobe
- wr_addr_o  out  A_WIDTH  shared write/read address
- wr_data_o  out  3*D_WIDTH  write data
- rd_en_o  out  STAGES  one-hot RAM read strobe
- rd_data_i  in  STAGES*3*D_WIDTH  read data, stage s at slice s
- busy_o  out  1  load in progress; lookups must be blocked
- done_o  out  1  one-cycle pulse at end of load
- err_o  out  1  sticky error flag
- err_cnt_o  out  16  saturating error count

Behaviour:
- Reset (async assert, sync deassert): state IDLE; all outputs 0 except rec_ready_o=1; err cleared. RAM contents are untouched. Reset mid-record abandons the record; no write occurs after assertion.
- FSM states:
  - IDLE: rec_ready_o=1. Handshake = rec_valid_i & rec_ready_o. On handshake, latch stage/addr/data/last, set busy_o, go to WRITE.
  - WRITE: one cycle; wr_en_o[stage]=1 with addr/data. Next state is READ if VERIFY_EN, otherwise IDLE.
  - READ: one cycle; rd_en_o[stage]=1, same addr. Next is WAIT if RD_LATENCY>1, otherwise CHECK.
  - WAIT: RD_LATENCY-1 cycles, counted down, then CHECK.
  - CHECK: compare rd_data_i slice[stage] with latched data. On mismatch, err_cnt++ and err_o=1. Go to IDLE.
- Timing, handshake at cycle T:
  - Write strobe at T+1.
  - VERIFY_EN=0: ready again at T+2, so 2 cycles per record.
  - VERIFY_EN=1: read strobe at T+2, CHECK at T+2+RD_LATENCY, ready at T+3+RD_LATENCY.
- rec_ready_o is 0 in every state except IDLE. Inputs are ignored when not ready.
- Stage index ≥ STAGES (possible when STAGES is not a power of 2):
  - No write or read strobe.
  - err_cnt++ and err_o=1 in the WRITE cycle.
  - FSM returns directly to IDLE.
  - rec_last_i is still honoured.
- Completion: if the latched last=1, done_o pulses in the first IDLE cycle after the record completes; busy_o deasserts in that same cycle. busy_o is never high while in IDLE except during the handshake-to-WRITE transition.
- Error status:
  - err_cnt_o saturates at 16'hFFFF; err_o stays 1.
  - clear_err_i zeroes both on the next edge.
  - clear_err_i has priority over a same-cycle increment, which is lost.
- Strobes: wr_en_o and rd_en_o are never both nonzero in the same cycle, and each is at most one-hot.

Test Plan:
- VERIFY_EN=0, STAGES=8: records (stage 3, addr 0x10, {1,2,3}) then (stage 7, addr 0xFF, {4,5,6}, last) → wr_en_o=8'h08 at T+1 and 8'h80 two cycles later; done_o pulses once; busy_o falls with done_o.
- VERIFY_EN=1, RD_LATENCY=2, behavioural RAM model: 4 records → rd_en_o 1 cycle after each wr_en_o; handshakes 5 cycles apart; err_cnt_o=0.
- RAM model corrupts stage 2, addr 0x05 readback → err_o=1 and err_cnt_o=1 after CHECK; later records load normally; clear_err_i → both 0 next cycle.
- STAGES=6, rec_stage_i=7 → no strobes; err_cnt_o increments by 1; FSM back in IDLE 1 cycle after WRITE.
- Drive rec_valid_i continuously with back-to-back records; toggle valid while ready=0 → no record lost or duplicated; write count equals handshake count. Pulse rst_n_i low during READ → all strobes 0 immediately; err cleared; next record is accepted normally.

Source files
------------

// File: rtl/qtree_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : qtree_cfg_loader
// Brief    : Streams quadtree node records into per-stage node RAMs, with
//            optional read-back verification and lookup hold-off while loading.
// Revision : 1.0
// ============================================================================
module qtree_cfg_loader #(
    parameter int STAGES     = 8,
    parameter int A_WIDTH    = 8,
    parameter int D_WIDTH    = 16,
    parameter int VERIFY_EN  = 1,
    parameter int RD_LATENCY = 1,
    localparam int SW        = $clog2(STAGES)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          rec_valid_i,
    output logic                          rec_ready_o,
    input  logic [SW-1:0]                 rec_stage_i,
    input  logic [A_WIDTH-1:0]            rec_addr_i,
    input  logic [3*D_WIDTH-1:0]          rec_data_i,
    input  logic                          rec_last_i,
    input  logic                          clear_err_i,
    output logic [STAGES-1:0]             wr_en_o,
    output logic [A_WIDTH-1:0]            wr_addr_o,
    output logic [3*D_WIDTH-1:0]          wr_data_o,
    output logic [STAGES-1:0]             rd_en_o,
    input  logic [STAGES*3*D_WIDTH-1:0]   rd_data_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic [15:0]                   err_cnt_o
);

    localparam int         c_DW     = 3 * D_WIDTH;
    localparam int         c_CW     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [c_CW-1:0] c_WAIT_INIT = (RD_LATENCY > 1) ? c_CW'(RD_LATENCY - 2) : '0;
    localparam logic [SW:0] c_STAGES = (SW+1)'(STAGES);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [SW-1:0]      r_stage;
    logic [A_WIDTH-1:0] r_addr;
    logic [c_DW-1:0]    r_data;
    logic               r_last;
    logic [c_CW-1:0]    r_wait;
    logic               r_done;
    logic               r_err;
    logic [15:0]        r_err_cnt;

    logic               w_hs;
    logic               w_stage_ok;
    logic [STAGES-1:0]  w_onehot;
    logic [c_DW-1:0]    w_rd_sel;
    logic               w_err_inc;

    assign w_hs       = rec_valid_i && (r_state == S_IDLE);
    // Stage indices past STAGES exist only when STAGES is not a power of two.
    assign w_stage_ok = ({1'b0, r_stage} < c_STAGES);
    assign w_onehot   = w_stage_ok ? ({{(STAGES-1){1'b0}}, 1'b1} << r_stage) : '0;

    always_comb begin
        w_rd_sel = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (r_stage == SW'(s)) begin
                w_rd_sel = rd_data_i[s*c_DW +: c_DW];
            end
        end
    end

    assign w_err_inc = ((r_state == S_WRITE) && !w_stage_ok) ||
                       ((r_state == S_CHECK) && (w_rd_sel != r_data));

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = (w_stage_ok && (VERIFY_EN != 0)) ? S_READ : S_IDLE;
            S_READ:  w_state_nxt = (RD_LATENCY > 1) ? S_WAIT : S_CHECK;
            S_WAIT:  if (r_wait == '0) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Record latch, wait counter, completion pulse and error status
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_stage   <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_last    <= 1'b0;
            r_wait    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_hs) begin
                r_stage <= rec_stage_i;
                r_addr  <= rec_addr_i;
                r_data  <= rec_data_i;
                r_last  <= rec_last_i;
            end
            if (r_state == S_READ) begin
                r_wait <= c_WAIT_INIT;
            end else if (r_state == S_WAIT) begin
                r_wait <= r_wait - 1'b1;
            end
            r_done <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE) && r_last;
            // A clear wins over an error raised in the same cycle.
            if (clear_err_i) begin
                r_err     <= 1'b0;
                r_err_cnt <= '0;
            end else if (w_err_inc) begin
                r_err <= 1'b1;
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        rec_ready_o = (r_state == S_IDLE);
        busy_o      = (r_state != S_IDLE) || w_hs;
        wr_en_o     = (r_state == S_WRITE) ? w_onehot : '0;
        rd_en_o     = (r_state == S_READ)  ? w_onehot : '0;
    end

    assign wr_addr_o = r_addr;
    assign wr_data_o = r_data;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_qtree_cfg_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_qtree_cfg_loader
// Brief    : Directed bench for a write-only loader (8 stages) and a verifying
//            loader (6 stages, read latency 2) backed by a behavioural RAM.
// Revision : 1.0
// ============================================================================
module tb_qtree_cfg_loader;

    typedef struct {
        logic [2:0]  stage;
        logic [7:0]  addr;
        logic [47:0] data;
        logic        last;
        logic [7:0]  exp_en;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_a = 1'b0, valid_b = 1'b0;
    logic [2:0]   stage = '0;
    logic [7:0]   addr = '0;
    logic [47:0]  data = '0;
    logic         last = 1'b0;
    logic         clear = 1'b0;
    logic         corrupt = 1'b0;

    logic         rdy_a, busy_a, done_a, err_a;
    logic [7:0]   wr_en_a, rd_en_a, wr_addr_a;
    logic [47:0]  wr_data_a;
    logic [15:0]  cnt_a;
    logic [383:0] rd_data_a = '0;

    logic         rdy_b, busy_b, done_b, err_b;
    logic [5:0]   wr_en_b, rd_en_b;
    logic [7:0]   wr_addr_b;
    logic [47:0]  wr_data_b;
    logic [15:0]  cnt_b;
    logic [287:0] rd_data_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qtree_cfg_loader #(.STAGES(8), .A_WIDTH(8), .D_WIDTH(16), .VERIFY_EN(0), .RD_LATENCY(1)) u_wo (
        .clk_i(clk), .rst_n_i(rst_n), .rec_valid_i(valid_a), .rec_ready_o(rdy_a),
        .rec_stage_i(stage), .rec_addr_i(addr), .rec_data_i(data), .rec_last_i(last),
        .clear_err_i(clear), .wr_en_o(wr_en_a), .wr_addr_o(wr_addr_a), .wr_data_o(wr_data_a),
        .rd_en_o(rd_en_a), .rd_data_i(rd_data_a), .busy_o(busy_a), .done_o(done_a),
        .err_o(err_a), .err_cnt_o(cnt_a)
    );

    qtree_cfg_loader #(.STAGES(6), .A_WIDTH(8), .D_WIDTH(16), .VERIFY_EN(1), .RD_LATENCY(2)) u_vf (
        .clk_i(clk), .rst_n_i(rst_n), .rec_valid_i(valid_b), .rec_ready_o(rdy_b),
        .rec_stage_i(stage), .rec_addr_i(addr), .rec_data_i(data), .rec_last_i(last),
        .clear_err_i(clear), .wr_en_o(wr_en_b), .wr_addr_o(wr_addr_b), .wr_data_o(wr_data_b),
        .rd_en_o(rd_en_b), .rd_data_i(rd_data_b), .busy_o(busy_b), .done_o(done_b),
        .err_o(err_b), .err_cnt_o(cnt_b)
    );

    // Node RAMs with a two-cycle read pipeline; stage 2 / addr 0x05 can be corrupted.
    logic [47:0] mem [6][256];
    logic [47:0] p1 [6];
    logic [47:0] p2 [6];

    always @(posedge clk) begin
        for (int s = 0; s < 6; s++) begin
            if (wr_en_b[s]) mem[s][wr_addr_b] <= wr_data_b;
            if (|rd_en_b) p1[s] <= mem[s][wr_addr_b] ^
                ((corrupt && s == 2 && wr_addr_b == 8'h05) ? 48'h1 : 48'h0);
            p2[s] <= p1[s];
        end
    end

    always_comb begin
        for (int s = 0; s < 6; s++) rd_data_b[s*48 +: 48] = p2[s];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one record and returns one cycle after the handshake edge.
    task automatic send(input bit b, input logic [2:0] s, input logic [7:0] a,
                        input logic [47:0] d, input logic l, output int hs_cyc);
        bit got = 0;
        stage = s; addr = a; data = d; last = l;
        if (b) valid_b = 1'b1; else valid_a = 1'b1;
        hs_cyc = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            if (b ? rdy_b : rdy_a) begin
                got = 1;
                hs_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t va [4];
        vec_t vb [4];
        int h, hp, hs_n, wr_n;
        logic [10:0] q [$];
        logic [10:0] e;

        va[0] = '{3'd3, 8'h10, 48'h0001_0002_0003, 1'b0, 8'h08};
        va[1] = '{3'd7, 8'hFF, 48'h0004_0005_0006, 1'b1, 8'h80};
        va[2] = '{3'd0, 8'h00, 48'hAAAA_5555_FFFF, 1'b0, 8'h01};
        va[3] = '{3'd5, 8'h3C, 48'h1234_5678_9ABC, 1'b1, 8'h20};
        vb[0] = '{3'd0, 8'h01, 48'h0123_4567_89AB, 1'b0, 8'h01};
        vb[1] = '{3'd5, 8'hA0, 48'hDEAD_BEEF_CAFE, 1'b0, 8'h20};
        vb[2] = '{3'd3, 8'h7F, 48'hFFFF_0000_FFFF, 1'b0, 8'h08};
        vb[3] = '{3'd2, 8'h06, 48'h0F0F_F0F0_1234, 1'b1, 8'h04};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        chk("reset_a", {rdy_a, busy_a, done_a, err_a, wr_en_a, rd_en_a, cnt_a}, {1'b1, 35'd0});
        chk("reset_b", {rdy_b, busy_b, done_b, err_b, wr_en_b, rd_en_b, cnt_b}, {1'b1, 31'd0});

        // Write-only loader: table of records, two cycles each.
        hp = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, va[i].stage, va[i].addr, va[i].data, va[i].last, h);
            if (i > 0) chk("a_hs_spacing", 64'(h - hp), 64'd2);
            hp = h;
            chk("a_wr_en", wr_en_a, va[i].exp_en);
            chk("a_wr_addr", wr_addr_a, va[i].addr);
            chk("a_wr_data", wr_data_a, va[i].data);
            chk("a_busy_rdy_rd", {busy_a, rdy_a, |rd_en_a}, 3'b100);
            tick(1);
            chk("a_idle_done", {rdy_a, done_a, busy_a, wr_en_a}, {1'b1, va[i].last, 1'b0, 8'h00});
        end
        tick(1);
        chk("a_done_once", done_a, 1'b0);

        // Back-to-back and toggling valid: every handshake yields exactly one write.
        hs_n = 0; wr_n = 0;
        for (int c = 0; c < 40; c++) begin
            valid_a = ((c % 3) != 2);
            stage = 3'(c * 5);
            addr  = 8'(c + 8'h40);
            data  = {16'(c), 16'hBEEF, 16'(~c)};
            last  = 1'b0;
            #1;
            if (valid_a && rdy_a) begin
                hs_n++;
                q.push_back({stage, addr});
            end
            @(posedge clk);
            #1;
            if (wr_en_a != 8'h00) begin
                wr_n++;
                if (q.size() == 0) begin
                    chk("stress_spurious_wr", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("stress_wr_addr", wr_addr_a, e[7:0]);
                    chk("stress_wr_en", wr_en_a, 8'(8'h01 << e[10:8]));
                end
            end
        end
        valid_a = 1'b0;
        chk("stress_counts", 64'(wr_n), 64'(hs_n));
        chk("stress_hs_seen", 64'(hs_n >= 10), 64'd1);

        // Verifying loader: write at T+1, read at T+2, ready at T+5.
        tick(2);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, vb[i].stage, vb[i].addr, vb[i].data, vb[i].last, h);
            if (i > 0) chk("b_hs_spacing", 64'(h - hp), 64'd5);
            hp = h;
            chk("b_wr_en", {wr_en_b, rd_en_b}, {vb[i].exp_en[5:0], 6'h00});
            tick(1);
            chk("b_rd_en", {rd_en_b, wr_en_b}, {vb[i].exp_en[5:0], 6'h00});
            chk("b_rd_addr", wr_addr_b, vb[i].addr);
        end
        tick(3);
        chk("b_done_clean", {done_b, busy_b, rdy_b, err_b, cnt_b}, {3'b101, 1'b0, 16'd0});

        // Corrupted readback raises the error after CHECK only.
        corrupt = 1'b1;
        send(1'b1, 3'd2, 8'h05, 48'h1111_2222_3333, 1'b0, h);
        tick(3);
        chk("corrupt_in_check", {err_b, cnt_b}, {1'b0, 16'd0});
        tick(1);
        chk("corrupt_err", {err_b, cnt_b}, {1'b1, 16'd1});
        send(1'b1, 3'd4, 8'h22, 48'h0A0B_0C0D_0E0F, 1'b0, h);
        tick(4);
        chk("after_corrupt_ok", {rdy_b, err_b, cnt_b}, {1'b1, 1'b1, 16'd1});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_err", {err_b, cnt_b}, 17'd0);

        // Out-of-range stage: no strobes, error, straight back to IDLE, last honoured.
        send(1'b1, 3'd7, 8'h33, 48'h7777_7777_7777, 1'b1, h);
        chk("bad_stage_strobes", {wr_en_b, rd_en_b, cnt_b}, 28'd0);
        tick(1);
        chk("bad_stage_idle", {rdy_b, done_b, err_b, rd_en_b, cnt_b}, {3'b111, 6'h00, 16'd1});

        // Clear in the same cycle as an increment wins.
        send(1'b1, 3'd6, 8'h34, 48'h6666_6666_6666, 1'b0, h);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("clear_priority", {rdy_b, err_b, cnt_b}, {1'b1, 1'b0, 16'd0});

        // Reset during READ abandons the record and clears error status.
        send(1'b1, 3'd7, 8'h35, 48'h0, 1'b0, h);
        tick(1);
        chk("pre_reset_cnt", cnt_b, 16'd1);
        send(1'b1, 3'd1, 8'h40, 48'h4040_4040_4040, 1'b1, h);
        tick(1);
        chk("pre_reset_read", rd_en_b, 6'h02);
        rst_n = 1'b0;
        #1;
        chk("reset_in_read", {wr_en_b, rd_en_b, err_b, cnt_b, busy_b, done_b, rdy_b}, {36'd0, 1'b1});
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 3'd1, 8'h41, 48'h4141_4141_4141, 1'b1, h);
        chk("post_reset_wr", {wr_en_b, wr_addr_b}, {6'h02, 8'h41});
        tick(4);
        chk("post_reset_done", {done_b, busy_b, err_b, cnt_b}, {1'b1, 1'b0, 1'b0, 16'd0});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
